mips32_dbg_loader: RTL and testbench
====================================

Name: mips32_dbg_loader

Overview:
- Host-side debug/load port for the pipelined MIPS32 core.
- Replaces bench-side hierarchical pokes of instruction memory, PC and HALTED, and peeks of the register file, with a valid/ready command/response protocol.
- Host direction: receives commands (write memory word, read register, start run, dump after halt).
- Core direction: drives the memory write port, the register read port and run control; returns register contents on a response stream.
- Sits between the host/bench driver and the core's Mem/Reg arrays; clocked on the core's first phase clock.

Parameters:
- ADDR_W, 10, instruction/data memory word-address width.
- NUM_REGS, 32, registers returned by a dump; also the register-index range.
- RUN_PULSE, 2, cycles core_init is held high on RUN.

Ports:
- clk1  in  1  clock; the core's phase-1 clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  00 MEMWR, 01 REGRD, 10 RUN, 11 DUMP.
- cmd_addr  in  ADDR_W  memory word address (MEMWR) or register index in low 5 bits (REGRD).
- cmd_wdata  in  32  memory write data (MEMWR).
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  register value (or checksum).
- rsp_last  out  1  final word of a response burst.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  32  memory write data.
- reg_raddr  out  5  register-file read index.
- reg_rdata  in  32  register data; valid one cycle after reg_raddr.
- core_init  out  1  held high: core forces PC=0, HALTED=0, TAKEN_BRANCH=0.
- core_halted  in  1  core HALTED flag.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_raddr=0, core_init=0, busy=0. FSM enters IDLE.
- Reset mid-operation: abandons any burst; no further mem_we; a pending response is dropped.
- cmd_ready=1 only in IDLE. In IDLE, rsp_valid=0.
- States and transitions:
  - IDLE: on accept, go to MEMWR, REGRD, RUN or DWAIT according to cmd_op.
  - MEMWR: mem_we=1 for exactly one cycle with the latched addr/data, then IDLE. Command accept to mem_we is 1 cycle.
  - REGRD: drive reg_raddr = cmd_addr[4:0], then RWAIT (1 cycle). Capture reg_rdata into rsp_data, then RESP with rsp_valid=1 and rsp_last=1.
  - RESP: hold rsp_valid and rsp_data stable until rsp_ready. On handshake, go to IDLE.
  - RUN: core_init high for RUN_PULSE cycles, then IDLE.
  - DWAIT: wait until core_halted=1, with no timeout.
  - Dump burst: index i runs 0..NUM_REGS-1. For each index, issue the read, wait 1 cycle, then present the response. rsp_last=1 only on the final word. The index increments only on handshake.
- Back-to-back: the next command is accepted the cycle after return to IDLE. Minimum MEMWR throughput is 1 command per 2 cycles.
- rsp_ready held low stalls indefinitely. The core is not affected.
- If the host drops rsp_ready mid-dump, no word is skipped or duplicated.

Optional Feature:
- DBG_CHECKSUM_EN defined: DUMP appends one extra word, the XOR of all NUM_REGS values. rsp_last moves to that word, giving NUM_REGS+1 words per dump.
- Not defined: NUM_REGS words per dump; no checksum logic.

Test Plan:
- Reset with cmd_valid=1 -> all outputs 0. After reset deasserts, cmd_ready=1 next cycle.
- MEMWR addr 0 data 32'h2801000a, then addr 8 data 32'hfc000000 -> exactly two mem_we pulses, each 1 cycle after accept, with matching addr/data.
- Register stub holds Reg[k]=k; REGRD addr 5 -> single response rsp_data=5 with rsp_last=1. Hold rsp_ready low for 4 cycles -> rsp_data stays 5 throughout.
- RUN -> core_init high for exactly 2 cycles. DUMP with core_halted=0 for 10 cycles -> no rsp_valid. Stub Reg1..5=10,20,25,30,55, then raise core_halted -> 32 words in order, rsp_last only on R31.
- Same dump with random rsp_ready gaps -> identical sequence. With DBG_CHECKSUM_EN, a 33rd word equals the XOR of all 32 words, with rsp_last on it.
- Assert rst on word 7 of a dump -> rsp_valid=0 next cycle. A new REGRD then works normally.

Source files
------------

// File: rtl/mips32_dbg_loader.sv
// mips32_dbg_loader: host-side debug/load port for the pipelined MIPS32 core.
// Accepts host commands (MEMWR, REGRD, RUN, DUMP) over a valid/ready stream and
// turns them into memory writes, register reads and run control on the core.
// Optional feature macro: DBG_CHECKSUM_EN appends an XOR checksum word to DUMP.
//
// Handshake: a word moves on any rising clk1 edge where valid and ready are
// both high. Once raised, valid and its payload stay stable until that edge.
module mips32_dbg_loader #(
  parameter int ADDR_W    = 10,
  parameter int NUM_REGS  = 32,
  parameter int RUN_PULSE = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              core_init,
  input  logic              core_halted,
  output logic              busy,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_MEMWR, S_REGRD, S_RWAIT, S_RESP, S_RUN,
    S_DWAIT, S_DREAD, S_DRWAIT, S_DRESP
`ifdef DBG_CHECKSUM_EN
    , S_DCSUM
`endif
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
  localparam int RUN_CNT_W = (RUN_PULSE > 1) ? $clog2(RUN_PULSE) : 1;
  localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(RUN_PULSE - 1);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [4:0]          reg_raddr_q, reg_raddr_d;
  logic                core_init_q, core_init_d;
  logic                busy_q, busy_d;
  logic [4:0]          idx_q, idx_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
`ifdef DBG_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic cmd_accept;
  logic rsp_fire;

  assign cmd_accept = cmd_valid & cmd_ready_q;
  assign rsp_fire   = rsp_valid_q & rsp_ready;

  // Next-state logic; every registered output is derived from the next state.
  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_raddr_d = reg_raddr_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
`ifdef DBG_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (cmd_op)
            2'b00: begin
              state_d     = S_MEMWR;
              mem_addr_d  = cmd_addr;
              mem_wdata_d = cmd_wdata;
            end
            2'b01: begin
              state_d     = S_REGRD;
              reg_raddr_d = cmd_addr[4:0];
            end
            2'b10: begin
              state_d   = S_RUN;
              run_cnt_d = '0;
            end
            default: begin
              state_d = S_DWAIT;
              idx_d   = '0;
`ifdef DBG_CHECKSUM_EN
              csum_d  = '0;
`endif
            end
          endcase
        end
      end
      S_MEMWR: state_d = S_IDLE;
      S_REGRD: state_d = S_RWAIT;
      S_RWAIT: begin
        state_d    = S_RESP;
        rsp_data_d = reg_rdata;
      end
      S_RESP: if (rsp_fire) state_d = S_IDLE;
      S_RUN: begin
        if (run_cnt_q == RUN_LAST) state_d = S_IDLE;
        else                       run_cnt_d = run_cnt_q + 1'b1;
      end
      S_DWAIT: begin
        if (core_halted) begin
          state_d     = S_DREAD;
          reg_raddr_d = idx_q;
        end
      end
      S_DREAD: state_d = S_DRWAIT;
      S_DRWAIT: begin
        state_d    = S_DRESP;
        rsp_data_d = reg_rdata;
`ifdef DBG_CHECKSUM_EN
        csum_d     = csum_q ^ reg_rdata;
`endif
      end
      S_DRESP: begin
        // Index only advances on handshake, so a stalled host never loses a word.
        if (rsp_fire) begin
          if (idx_q == LAST_IDX) begin
`ifdef DBG_CHECKSUM_EN
            state_d    = S_DCSUM;
            rsp_data_d = csum_q;
`else
            state_d    = S_IDLE;
`endif
          end else begin
            state_d     = S_DREAD;
            idx_d       = idx_q + 5'd1;
            reg_raddr_d = idx_q + 5'd1;
          end
        end
      end
`ifdef DBG_CHECKSUM_EN
      S_DCSUM: if (rsp_fire) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    mem_we_d    = (state_d == S_MEMWR);
    core_init_d = (state_d == S_RUN);
    rsp_valid_d = (state_d == S_RESP) || (state_d == S_DRESP);
    rsp_last_d  = (state_d == S_RESP);
`ifdef DBG_CHECKSUM_EN
    if (state_d == S_DCSUM) begin
      rsp_valid_d = 1'b1;
      rsp_last_d  = 1'b1;
    end
`else
    if (state_d == S_DRESP && idx_d == LAST_IDX) rsp_last_d = 1'b1;
`endif
  end

  // State and output registers with synchronous reset; reset drops any burst.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_raddr_q <= '0;
      core_init_q <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      run_cnt_q   <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_raddr_q <= reg_raddr_d;
      core_init_q <= core_init_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
`ifdef DBG_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign reg_raddr = reg_raddr_q;
  assign core_init = core_init_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips32_dbg_loader.sv
// Directed bench for mips32_dbg_loader with a register-file stub (Reg[k]=k).
module tb_mips32_dbg_loader;
  localparam int ADDR_W    = 10;
  localparam int NUM_REGS  = 32;
  localparam int RUN_PULSE = 2;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [4:0]        reg_raddr;
  logic [31:0]       reg_rdata;
  logic              core_init;
  logic              core_halted;
  logic              busy;
  logic [3:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int we_pulses = 0;

  logic [31:0] regs [NUM_REGS];
  logic [31:0] exp_q [$];

  mips32_dbg_loader #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RUN_PULSE(RUN_PULSE)
  ) dut (
    .clk1(clk1), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .core_init(core_init), .core_halted(core_halted),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset block
  always #5 clk1 = ~clk1;

  // Register-file stub: one-cycle read latency
  always @(posedge clk1) reg_rdata <= regs[reg_raddr];

  // Count memory write strobes
  always @(negedge clk1) if (mem_we === 1'b1) we_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one command; returns just after the accepting edge
  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(posedge clk1); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(negedge clk1);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (cmd_ready !== 1'b1) check_eq("cmd_accept_timeout", 32'(n), 32'd0);
    @(posedge clk1); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic memwr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    send_cmd(2'b00, a, d);
    @(negedge clk1);
    check_eq("memwr_we", 32'(mem_we), 32'd1);
    check_eq("memwr_addr", 32'(mem_addr), 32'(a));
    check_eq("memwr_data", mem_wdata, d);
    @(negedge clk1);
    check_eq("memwr_we_off", 32'(mem_we), 32'd0);
  endtask

  task automatic regrd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input int hold);
    int lat;
    lat = 0;
    send_cmd(2'b01, a, 32'd0);
    do begin
      @(negedge clk1);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 20);
    check_eq("regrd_latency", 32'(lat), 32'd3);
    check_eq("regrd_data", rsp_data, exp);
    check_eq("regrd_last", 32'(rsp_last), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk1);
      check_eq("regrd_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("regrd_hold_data", rsp_data, exp);
    end
    rsp_ready = 1'b1;
    @(negedge clk1);
    check_eq("regrd_done_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  task automatic fill_exp();
    logic [31:0] cs;
    cs = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(regs[i]);
      cs = cs ^ regs[i];
    end
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  // Scoreboard: drain a dump burst against exp_q
  task automatic collect_dump(input string tag, input bit gaps);
    int guard;
    logic [31:0] e;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      @(negedge clk1);
      guard++;
      rsp_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, rsp_data, e);
        check_eq({tag, "_last"}, 32'(rsp_last), (exp_q.size() == 0) ? 32'd1 : 32'd0);
      end
    end
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk1); #1;
    rsp_ready = 1'b0;
    @(negedge clk1);
    check_eq({tag, "_end_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    int hs;
    int guard;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'(k);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = 32'hdeadbeef;
    rsp_ready = 1'b0; core_halted = 1'b0;

    // Reset with a command offered: every output stays low
    repeat (3) @(negedge clk1);
    check_eq("rst_ctrl", {26'd0, cmd_ready, rsp_valid, rsp_last, mem_we, core_init, busy}, 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_reg_raddr", 32'(reg_raddr), 32'd0);
    @(posedge clk1); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Memory loads
    memwr(10'd0, 32'h2801000a);
    memwr(10'd8, 32'hfc000000);

    // Single register reads, including a stalled response and upper address bits
    regrd(10'd5, 32'd5, 4);
    regrd(10'h3e7, 32'd7, 0);
    regrd(10'd31, 32'd31, 1);

    // RUN pulse width
    send_cmd(2'b10, '0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      if (i == 0) check_eq("run_first", 32'(core_init), 32'd1);
      if (core_init === 1'b1) cnt++;
    end
    check_eq("run_pulse_len", 32'(cnt), 32'd2);
    check_eq("run_idle_busy", 32'(busy), 32'd0);

    // DUMP waits for HALTED
    send_cmd(2'b11, '0, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      if (rsp_valid !== 1'b0) cnt++;
    end
    check_eq("dwait_no_valid", 32'(cnt), 32'd0);
    check_eq("dwait_busy", 32'(busy), 32'd1);
    regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'd25; regs[4] = 32'd30; regs[5] = 32'd55;
    fill_exp();
    core_halted = 1'b1;
    collect_dump("dump", 1'b0);

    // Same dump with host back-pressure
    send_cmd(2'b11, '0, 32'd0);
    fill_exp();
    collect_dump("dump_gap", 1'b1);

    // Reset while word 7 of a dump is on offer
    send_cmd(2'b11, '0, 32'd0);
    hs = 0; guard = 0;
    rsp_ready = 1'b1;
    while (guard < 500) begin
      @(negedge clk1);
      guard++;
      if (rsp_valid === 1'b1) begin
        if (hs == 7) break;
        hs++;
      end
    end
    check_eq("mid_rst_word_idx", 32'(hs), 32'd7);
    check_eq("mid_rst_word7", rsp_data, 32'd7);
    rst = 1'b1; rsp_ready = 1'b0;
    @(negedge clk1);
    check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk1); #1;
    rst = 1'b0;
    regrd(10'd3, 32'd25, 2);

    check_eq("mem_we_pulses", 32'(we_pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
